// File: rtl/gbe_mac_pkg.sv
// ---------------------------------------------------------------------------
// gbe_mac_pkg
// Shared definitions for the GMII receive framer.
//   rx_state_e     receive framer states
//   PREAMBLE_BYTE  preamble octet seen on GMII before the SFD
//   SFD_BYTE       start-of-frame delimiter octet
//   CRC_INIT       CRC32 register value loaded at the SFD
//   CRC_POLY       reflected Ethernet CRC32 polynomial
//   CRC_RESIDUE    CRC register value after a frame with an intact FCS
//   LEN_W          width of the saturating frame byte counter
// ---------------------------------------------------------------------------
package gbe_mac_pkg;

  typedef enum logic [2:0] {
    RESYNC,
    IDLE,
    PRE,
    DATA,
    DROP,
    ABORT
  } rx_state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY      = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB_20E3;

  localparam int          LEN_W         = 11;

endpackage

// File: rtl/gbe_crc32_d8.sv
// ---------------------------------------------------------------------------
// gbe_crc32_d8
// Combinational next-state function of the Ethernet CRC32 for one byte.
// Reflected (LSB-first) form, polynomial 0xEDB88320, no final inversion:
// the caller owns the register, its initial value and the residue check.
// Ports:
//   crc_in   in  32  current CRC register value
//   data_in  in  8   byte being absorbed, bit 0 first on the wire
//   crc_out  out 32  CRC register value after absorbing data_in
// ---------------------------------------------------------------------------
module gbe_crc32_d8
  import gbe_mac_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;

  // Bit-serial LFSR unrolled over the eight data bits; the data byte is
  // folded into the low bits up front since the reflected form shifts right.
  always_comb begin
    crc_work = crc_in ^ {24'h00_0000, data_in};
    for (int i = 0; i < 8; i++) begin
      if (crc_work[0]) begin
        crc_work = (crc_work >> 1) ^ CRC_POLY;
      end else begin
        crc_work = crc_work >> 1;
      end
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/gbe_mac_rx.sv
// ---------------------------------------------------------------------------
// gbe_mac_rx
// GMII receive framer in the mac_clk domain. Strips preamble and SFD, passes
// frame bytes downstream with the trailing 4-byte FCS removed, checks FCS,
// length and rx_er, and marks the end of every accepted frame with exactly
// one single-cycle good or bad pulse. Keeps wrapping good/bad frame counters.
// Parameters:
//   MIN_FRAME  minimum legal frame length, DA through FCS inclusive
//   MAX_FRAME  maximum legal frame length, DA through FCS inclusive
// Ports:
//   mac_clk           in   1   125 MHz GMII receive clock
//   mac_rst_n         in   1   asynchronous active-low reset
//   gmii_rxd          in   8   GMII receive data
//   gmii_rx_dv        in   1   GMII receive data valid
//   gmii_rx_er        in   1   GMII receive error
//   rx_enable         in   1   frame accept enable, sampled at the SFD
//   mac_rx_data       out  8   frame byte, FCS excluded
//   mac_rx_dvld       out  1   mac_rx_data valid
//   mac_rx_goodframe  out  1   pulse: frame just ended is good
//   mac_rx_badframe   out  1   pulse: frame just ended is bad
//   stat_good_cnt     out  16  good frame count, wrapping
//   stat_bad_cnt      out  16  bad frame count, wrapping
// All outputs are registered and reset to zero.
// ---------------------------------------------------------------------------
module gbe_mac_rx
  import gbe_mac_pkg::*;
#(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        mac_clk,
  input  logic        mac_rst_n,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic        rx_enable,
  output logic [7:0]  mac_rx_data,
  output logic        mac_rx_dvld,
  output logic        mac_rx_goodframe,
  output logic        mac_rx_badframe,
  output logic [15:0] stat_good_cnt,
  output logic [15:0] stat_bad_cnt
);

  localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] MAX_LEN   = LEN_W'(MAX_FRAME);
  localparam logic [LEN_W-1:0] ABORT_LEN = LEN_W'(MAX_FRAME + 1);
  localparam logic [LEN_W-1:0] LEN_SAT   = '1;
  localparam logic [LEN_W-1:0] FCS_LEN   = LEN_W'(4);

  rx_state_e         state_q, state_d;
  logic [3:0][7:0]   dly_q, dly_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              err_q, err_d;
  logic [31:0]       crc_q, crc_d;
  logic [7:0]        data_q, data_d;
  logic              dvld_q, dvld_d;
  logic              good_q, good_d;
  logic              bad_q, bad_d;
  logic [15:0]       good_cnt_q, good_cnt_d;
  logic [15:0]       bad_cnt_q, bad_cnt_d;

  logic [31:0]       crc_next;
  logic [LEN_W-1:0]  len_inc;
  logic              frame_good;
  logic              sfd_seen;
  logic              end_of_frame;

  gbe_crc32_d8 u_crc (
    .crc_in  (crc_q),
    .data_in (gmii_rxd),
    .crc_out (crc_next)
  );

  // The counter saturates so an oversize frame can never wrap back into the
  // legal length window; in practice ABORT stops it long before that.
  assign len_inc = (len_q == LEN_SAT) ? len_q : len_q + LEN_W'(1);

  // Verdict for the frame that is closing; only consulted at end of frame.
  assign frame_good = !err_q && (len_q >= MIN_LEN) && (len_q <= MAX_LEN) &&
                      (crc_q == CRC_RESIDUE);

  assign sfd_seen = gmii_rx_dv && (gmii_rxd == SFD_BYTE);

  // Next-state, datapath and output computation. The delay line keeps the
  // last four bytes so that the FCS is never forwarded: a byte is released
  // only once four newer bytes have been seen, so the last four of the frame
  // are naturally swallowed when dv drops.
  always_comb begin
    state_d      = state_q;
    dly_d        = dly_q;
    len_d        = len_q;
    err_d        = err_q;
    crc_d        = crc_q;
    data_d       = data_q;
    dvld_d       = 1'b0;
    good_d       = 1'b0;
    bad_d        = 1'b0;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    end_of_frame = 1'b0;

    case (state_q)
      RESYNC: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end
      end

      IDLE, PRE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rxd == PREAMBLE_BYTE) begin
          state_d = PRE;
        end else if (sfd_seen && rx_enable) begin
          state_d = DATA;
          len_d   = '0;
          err_d   = 1'b0;
          crc_d   = CRC_INIT;
        end else begin
          state_d = DROP;
        end
      end

      DATA: begin
        if (gmii_rx_dv) begin
          dly_d = {dly_q[2:0], gmii_rxd};
          crc_d = crc_next;
          len_d = len_inc;
          if (gmii_rx_er) begin
            err_d = 1'b1;
          end
          if (len_inc == ABORT_LEN) begin
            err_d   = 1'b1;
            state_d = ABORT;
          end else if (len_q >= FCS_LEN) begin
            dvld_d = 1'b1;
            data_d = dly_q[3];
          end
        end else begin
          end_of_frame = 1'b1;
          state_d      = IDLE;
        end
      end

      DROP: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end
      end

      ABORT: begin
        if (!gmii_rx_dv) begin
          end_of_frame = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = RESYNC;
      end
    endcase

    // Single verdict per frame; the counter moves with its pulse.
    if (end_of_frame) begin
      if (frame_good) begin
        good_d     = 1'b1;
        good_cnt_d = good_cnt_q + 16'd1;
      end else begin
        bad_d     = 1'b1;
        bad_cnt_d = bad_cnt_q + 16'd1;
      end
    end
  end

  // State and output registers. Reset lands in RESYNC so a frame already in
  // flight when reset lifts is ignored rather than parsed from its middle.
  always_ff @(posedge mac_clk or negedge mac_rst_n) begin
    if (!mac_rst_n) begin
      state_q    <= RESYNC;
      dly_q      <= '0;
      len_q      <= '0;
      err_q      <= 1'b0;
      crc_q      <= '0;
      data_q     <= '0;
      dvld_q     <= 1'b0;
      good_q     <= 1'b0;
      bad_q      <= 1'b0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      len_q      <= len_d;
      err_q      <= err_d;
      crc_q      <= crc_d;
      data_q     <= data_d;
      dvld_q     <= dvld_d;
      good_q     <= good_d;
      bad_q      <= bad_d;
      good_cnt_q <= good_cnt_d;
      bad_cnt_q  <= bad_cnt_d;
    end
  end

  assign mac_rx_data      = data_q;
  assign mac_rx_dvld      = dvld_q;
  assign mac_rx_goodframe = good_q;
  assign mac_rx_badframe  = bad_q;
  assign stat_good_cnt    = good_cnt_q;
  assign stat_bad_cnt     = bad_cnt_q;

endmodule
